combo_programmer: RTL and testbench

Writer side of the combination lock: captures a new 4-digit combination from the switch/key user interface, confirms it by re-entry, and drives the 16-bit combination word that the lock's comparator reads. It sits beside the lock FSM in the slow-clock domain, after the push-button edge detector. Writes are accepted only while the lock reports OPEN.

---
 rtl/combo_programmer_pkg.sv | 30 +++
 rtl/combo_programmer_idle_timer.sv | 26 ++
 rtl/combo_programmer.sv | 113 +++++++++++
 tb/tb_combo_programmer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/combo_programmer_pkg.sv
// Shared definitions for the combination-lock writer: state encodings,
// the default combination and the digit-k nibble slice used by lock and writer.
package combo_programmer_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    NEW1  = 4'd1,
    NEW2  = 4'd2,
    NEW3  = 4'd3,
    NEW4  = 4'd4,
    CONF1 = 4'd5,
    CONF2 = 4'd6,
    CONF3 = 4'd7,
    CONF4 = 4'd8
  } state_t;

  localparam logic [15:0] DEFAULT_COMBO_C = 16'h8421;

  // Digit 1 lives in [3:0], digit 4 in [15:12]; k is the zero-based digit index.
  function automatic logic [3:0] digit_slice(input logic [15:0] w, input logic [1:0] k);
    return w[{k, 2'b00} +: 4];
  endfunction

  function automatic logic [1:0] digit_index(input state_t s);
    logic [3:0] t;
    t = (s >= CONF1) ? (4'(s) - 4'd5) : (4'(s) - 4'd1);
    return t[1:0];
  endfunction

endpackage

// File: rtl/combo_programmer_idle_timer.sv
// Inactivity timer: counts busy cycles since the last accepted strobe and
// flags expiry when the count reaches TIMEOUT-1.
module idle_timer #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge CLOCK_50) begin
    if (reset)      r_count <= '0;
    else if (clear) r_count <= '0;
    else if (run)   r_count <= r_count + 1'b1;
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/combo_programmer.sv
// Writer side of the combination lock: captures a new 4-digit combination,
// confirms it by re-entry and commits it to the comparator word.
module combo_programmer
  import combo_programmer_pkg::*;
#(
  parameter logic [15:0] DEFAULT_COMBO = DEFAULT_COMBO_C,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned TO_W          = 11
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        unlocked,
  input  logic        prog,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic [15:0] combo,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  state_o
);

  state_t      r_state, w_next;
  logic [15:0] r_pending, r_combo;
  logic        r_busy, r_done, r_error;
  logic        w_done, w_error, w_start, w_write, w_accept;
  logic        w_expired, w_timer_clr, w_run;
  logic [1:0]  w_idx;

  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_error  = 1'b0;
    w_start  = 1'b0;
    w_write  = 1'b0;
    w_accept = 1'b0;
    w_idx    = digit_index(r_state);
    case (r_state)
      IDLE: begin
        if (prog && unlocked) begin
          w_next  = NEW1;
          w_start = 1'b1;
        end
      end
      NEW1, NEW2, NEW3, NEW4, CONF1, CONF2, CONF3, CONF4: begin
        // Unlock loss outranks a same-cycle digit, which outranks timeout.
        if (!unlocked) begin
          w_next  = IDLE;
          w_error = 1'b1;
        end else if (digit_valid) begin
          w_accept = 1'b1;
          if (r_state <= NEW4) begin
            w_write = 1'b1;
            w_next  = state_t'(4'(r_state) + 4'd1);
          end else if (digit != digit_slice(r_pending, w_idx)) begin
            w_next  = IDLE;
            w_error = 1'b1;
          end else if (r_state == CONF4) begin
            w_next = IDLE;
            w_done = 1'b1;
          end else begin
            w_next = state_t'(4'(r_state) + 4'd1);
          end
        end else if (w_expired) begin
          w_next  = IDLE;
          w_error = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Clearing whenever the next state is IDLE keeps the count at zero in IDLE.
  assign w_timer_clr = w_start | w_accept | (w_next == IDLE);
  assign w_run       = (r_state != IDLE);

  idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_idle_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (w_timer_clr),
    .run      (w_run),
    .expired  (w_expired)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_combo   <= DEFAULT_COMBO;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= w_done;
      r_error <= w_error;
      if (w_start)      r_pending <= '0;
      else if (w_write) r_pending[{w_idx, 2'b00} +: 4] <= digit;
      if (w_done)       r_combo <= r_pending;
    end
  end

  assign combo   = r_combo;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign state_o = r_state;

endmodule

// File: tb/tb_combo_programmer.sv
// Directed bench for combo_programmer: stimulus pushes expected done/error
// pulses into a scoreboard that a negedge monitor pops and checks.
module tb_combo_programmer;

  logic        CLOCK_50 = 1'b0;
  logic        reset, unlocked, prog, digit_valid;
  logic [3:0]  digit;
  logic [15:0] combo;
  logic        busy, done, error;
  logic [3:0]  state_o;

  always #5 CLOCK_50 = ~CLOCK_50;

  combo_programmer #(
    .DEFAULT_COMBO (16'h8421),
    .TIMEOUT       (8),
    .TO_W          (4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .unlocked    (unlocked),
    .prog        (prog),
    .digit_valid (digit_valid),
    .digit       (digit),
    .combo       (combo),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .state_o     (state_o)
  );

  typedef struct {
    bit          is_done;
    logic [15:0] combo;
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] exp_combo;
  int unsigned p;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input bit is_done, input logic [15:0] c, input int unsigned at);
    ev_t e;
    e.is_done = is_done;
    e.combo   = c;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic step(input bit p_i, input bit dv, input logic [3:0] d);
    prog        = p_i;
    digit_valid = dv;
    digit       = d;
    @(posedge CLOCK_50);
    #1;
    prog        = 1'b0;
    digit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  always @(negedge CLOCK_50) begin
    ev_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_pulse_cycle", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (done === 1'b1 || error === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse_done_error", {done, error}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_done", done, e.is_done);
        chk("pulse_error", error, !e.is_done);
        chk("combo_at_pulse", combo, e.combo);
        chk("state_at_pulse", state_o, 0);
        chk("busy_at_pulse", busy, 0);
      end
    end
  end

  initial begin
    reset = 1'b1; unlocked = 1'b0; prog = 1'b0; digit_valid = 1'b0; digit = '0;
    exp_combo = 16'h8421;
    idle(2);
    chk("reset_combo", combo, 16'h8421);
    chk("reset_state", state_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    reset = 1'b0;

    // Happy path with a short pause between entry and confirmation
    unlocked = 1'b1;
    idle(1);
    step(1, 0, 4'h0);
    chk("happy_state_new1", state_o, 1);
    chk("happy_busy", busy, 1);
    step(0, 1, 4'h3);
    chk("happy_state_new2", state_o, 2);
    step(0, 1, 4'h7);
    step(0, 1, 4'h0);
    step(0, 1, 4'hF);
    chk("happy_state_conf1", state_o, 5);
    idle(2);
    chk("happy_hold_conf1", state_o, 5);
    step(0, 1, 4'h3);
    step(0, 1, 4'h7);
    step(0, 1, 4'h0);
    chk("happy_state_conf4", state_o, 8);
    expect_pulse(1, 16'hF073, cyc + 1);
    step(0, 1, 4'hF);
    exp_combo = 16'hF073;
    chk("happy_combo", combo, 16'hF073);
    chk("happy_state_idle", state_o, 0);
    chk("happy_busy_low", busy, 0);

    reset = 1'b1;
    step(0, 0, 4'h0);
    reset = 1'b0;
    exp_combo = 16'h8421;
    chk("reset_restores_combo", combo, 16'h8421);

    // Mismatch on third confirm digit
    step(1, 0, 4'h0);
    step(0, 1, 4'h1); step(0, 1, 4'h2); step(0, 1, 4'h3); step(0, 1, 4'h4);
    step(0, 1, 4'h1); step(0, 1, 4'h2);
    expect_pulse(0, exp_combo, cyc + 1);
    step(0, 1, 4'h9);
    chk("mismatch_state", state_o, 0);
    chk("mismatch_combo", combo, 16'h8421);
    step(0, 1, 4'h3);
    step(0, 1, 4'h4);
    chk("mismatch_ignore_state", state_o, 0);
    chk("mismatch_ignore_busy", busy, 0);

    // Unlock loss in CONF2, then prog while locked
    step(1, 0, 4'h0);
    step(0, 1, 4'h5); step(0, 1, 4'h6); step(0, 1, 4'h7); step(0, 1, 4'h8);
    step(0, 1, 4'h5);
    chk("unlock_state_conf2", state_o, 6);
    unlocked = 1'b0;
    expect_pulse(0, exp_combo, cyc + 1);
    step(0, 0, 4'h0);
    chk("unlock_state_idle", state_o, 0);
    chk("unlock_combo", combo, exp_combo);
    step(1, 0, 4'h0);
    chk("locked_prog_state", state_o, 0);
    chk("locked_prog_busy", busy, 0);
    unlocked = 1'b1;

    // Digit and unlock-loss in the same cycle
    step(1, 0, 4'h0);
    step(0, 1, 4'hA);
    chk("abort_pri_new2", state_o, 2);
    unlocked = 1'b0;
    expect_pulse(0, exp_combo, cyc + 1);
    step(0, 1, 4'hB);
    chk("abort_pri_state", state_o, 0);
    unlocked = 1'b1;

    // prog with digit_valid in IDLE lands in NEW1, digit dropped
    step(1, 1, 4'hE);
    chk("prog_dv_state_new1", state_o, 1);
    step(0, 1, 4'h1); step(0, 1, 4'h2); step(0, 1, 4'h3); step(0, 1, 4'h4);
    step(0, 1, 4'h1); step(0, 1, 4'h2); step(0, 1, 4'h3);
    expect_pulse(1, 16'h4321, cyc + 1);
    step(0, 1, 4'h4);
    exp_combo = 16'h4321;
    chk("prog_dv_combo", combo, 16'h4321);

    // Timeout: error exactly TIMEOUT edges after the last accepted digit
    step(1, 0, 4'h0);
    step(0, 1, 4'h6);
    expect_pulse(0, exp_combo, cyc + 8);
    idle(7);
    chk("timeout_not_yet_state", state_o, 2);
    chk("timeout_not_yet_busy", busy, 1);
    idle(1);
    chk("timeout_state", state_o, 0);
    chk("timeout_combo", combo, 16'h4321);

    // Reset mid-entry in NEW3
    step(1, 0, 4'h0);
    step(0, 1, 4'h1);
    step(0, 1, 4'h2);
    chk("rst_mid_state_new3", state_o, 3);
    reset = 1'b1;
    step(0, 0, 4'h0);
    reset = 1'b0;
    exp_combo = 16'h8421;
    chk("rst_mid_combo", combo, 16'h8421);
    chk("rst_mid_state", state_o, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_error", error, 0);

    // Back-to-back: done on the ninth strobe cycle
    step(1, 0, 4'h0);
    p = cyc;
    expect_pulse(1, 16'h1C5A, p + 8);
    step(0, 1, 4'hA); step(0, 1, 4'h5); step(0, 1, 4'hC); step(0, 1, 4'h1);
    step(0, 1, 4'hA); step(0, 1, 4'h5); step(0, 1, 4'hC); step(0, 1, 4'h1);
    chk("b2b_combo", combo, 16'h1C5A);
    chk("b2b_state", state_o, 0);

    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
